// File: rtl/bcd_counter_bank.sv
// Packed-BCD counter bank with per-digit increment, one-digit-per-clock carry ripple
// and a display snapshot that is latched only on the refresh pulse.
module bcd_counter_bank #(
   parameter int DIGITS = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inc_i,
   input  logic                  ref_i,
   input  logic [DIGITS-1:0]     digit_sel_i,
   input  logic                  clr_i,
   output logic [4*DIGITS-1:0]   count_out_o,
   output logic                  busy_o,
   output logic                  overflow_o
);

   logic [4*DIGITS-1:0] digits_q, digits_d;
   logic [DIGITS-1:0]   pc_q, pc_d;
   logic [DIGITS-1:0]   add, carry;
   logic                overflow_q, overflow_d;

   assign busy_o     = |pc_q;
   assign overflow_o = overflow_q;

   // Handshake: inc_i is accepted only on a cycle where busy_o is low; a pulse
   // arriving while busy_o is high is dropped, so a carry and a fresh select
   // never land on the same digit in one cycle.
   always_comb begin
      digits_d   = digits_q;
      pc_d       = '0;
      carry      = '0;
      add        = pc_q | ({DIGITS{inc_i & ~busy_o}} & digit_sel_i);
      overflow_d = overflow_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (add[i]) begin
            if (digits_q[4*i +: 4] == 4'd9) begin
               digits_d[4*i +: 4] = 4'd0;
               carry[i]           = 1'b1;
            end else begin
               digits_d[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
            end
         end
      end
      for (int i = 0; i < DIGITS - 1; i++) begin
         pc_d[i+1] = carry[i];
      end
      // The top digit's wrap is only recorded, never propagated.
      if (carry[DIGITS-1]) begin
         overflow_d = 1'b1;
      end
      if (clr_i) begin
         digits_d   = '0;
         pc_d       = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits_q    <= '0;
         pc_q        <= '0;
         overflow_q  <= 1'b0;
         count_out_o <= '0;
      end else begin
         digits_q   <= digits_d;
         pc_q       <= pc_d;
         overflow_q <= overflow_d;
         if (ref_i) begin
            count_out_o <= digits_q;
         end
      end
   end

endmodule

// File: tb/tb_bcd_counter_bank.sv
// Directed bench for bcd_counter_bank: refresh snapshots are scored through an
// expected queue by a monitor; busy/overflow/reset behaviour is checked inline.
module tb_bcd_counter_bank;

   localparam int DIGITS = 6;
   localparam int W      = 4 * DIGITS;

   logic              clk;
   logic              reset;
   logic              inc_i;
   logic              ref_i;
   logic [DIGITS-1:0] digit_sel_i;
   logic              clr_i;
   logic [W-1:0]      count_out_o;
   logic              busy_o;
   logic              overflow_o;

   // Expected snapshot: {overflow, count_out} after each refresh edge.
   logic [W:0] exp_q[$];

   int vectors;
   int miscompares;
   int bcnt;

   bcd_counter_bank #(.DIGITS(DIGITS)) dut (
      .clk         (clk),
      .reset       (reset),
      .inc_i       (inc_i),
      .ref_i       (ref_i),
      .digit_sel_i (digit_sel_i),
      .clr_i       (clr_i),
      .count_out_o (count_out_o),
      .busy_o      (busy_o),
      .overflow_o  (overflow_o)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Driver tasks (inputs change on the falling edge)
   task automatic inc_pulse(input logic [DIGITS-1:0] sel);
      @(negedge clk);
      inc_i       = 1'b1;
      digit_sel_i = sel;
      @(negedge clk);
      inc_i       = 1'b0;
      digit_sel_i = '0;
   endtask

   task automatic preload(input logic [DIGITS-1:0] sel, input int n);
      repeat (n) inc_pulse(sel);
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr_i = 1'b1;
      @(negedge clk);
      clr_i = 1'b0;
   endtask

   task automatic do_ref(input logic [W-1:0] exp_cnt, input logic exp_ovf);
      @(negedge clk);
      ref_i = 1'b1;
      exp_q.push_back({exp_ovf, exp_cnt});
      @(negedge clk);
      ref_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Counts falling edges (starting now) on which busy_o is high.
   task automatic count_busy(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         if (busy_o) cnt++;
         @(negedge clk);
      end
   endtask

   // Scoreboard monitor: every refresh edge presents a new snapshot.
   initial begin
      logic [W:0] e;
      forever begin
         @(posedge clk);
         if (ref_i === 1'b1 && reset === 1'b0) begin
            #1;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL snapshot: refresh with no expected entry, count_out 0x%0h", count_out_o);
            end else begin
               e = exp_q.pop_front();
               check("count_out", 32'(count_out_o), 32'(e[W-1:0]));
               check("overflow_at_ref", 32'(overflow_o), 32'(e[W]));
            end
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      inc_i       = 1'b0;
      ref_i       = 1'b0;
      digit_sel_i = '0;
      clr_i       = 1'b0;
      #12;
      check("reset_count_out", 32'(count_out_o), 32'h0);
      check("reset_busy", 32'(busy_o), 32'h0);
      check("reset_overflow", 32'(overflow_o), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      idle(2);

      // Three spaced single-digit increments: never busy.
      for (int k = 0; k < 3; k++) begin
         inc_pulse(6'b000001);
         count_busy(20, bcnt);
         check("no_busy_simple", 32'(bcnt), 32'd0);
      end
      do_ref(24'h000003, 1'b0);

      // 000999 + 1: three ripple cycles.
      clr_pulse();
      preload(6'b000111, 9);
      do_ref(24'h000999, 1'b0);
      inc_pulse(6'b000001);
      count_busy(10, bcnt);
      check("busy_len_999", 32'(bcnt), 32'd3);
      do_ref(24'h001000, 1'b0);

      // 999999 + 1: full ripple, overflow sticky until clr.
      clr_pulse();
      preload(6'b111111, 9);
      do_ref(24'h999999, 1'b0);
      inc_pulse(6'b000001);
      count_busy(10, bcnt);
      check("busy_len_999999", 32'(bcnt), 32'd5);
      check("overflow_set", 32'(overflow_o), 32'h1);
      do_ref(24'h000000, 1'b1);
      idle(10);
      do_ref(24'h000000, 1'b1);
      clr_pulse();
      check("overflow_cleared", 32'(overflow_o), 32'h0);
      inc_pulse(6'b000001);
      do_ref(24'h000001, 1'b0);
      // clr and inc together: clr wins, snapshot untouched until next refresh.
      @(negedge clk);
      clr_i       = 1'b1;
      inc_i       = 1'b1;
      digit_sel_i = 6'b000001;
      @(negedge clk);
      clr_i       = 1'b0;
      inc_i       = 1'b0;
      digit_sel_i = '0;
      idle(2);
      check("count_out_hold_on_clr", 32'(count_out_o), 32'h000001);
      do_ref(24'h000000, 1'b0);

      // Multi-select on 000009, then top digit alone.
      preload(6'b000001, 9);
      inc_pulse(6'b000011);
      idle(6);
      do_ref(24'h000020, 1'b0);
      inc_pulse(6'b100000);
      idle(2);
      do_ref(24'h100020, 1'b0);

      // 000099 + 1 followed immediately by an inc while busy: dropped.
      clr_pulse();
      preload(6'b000011, 9);
      @(negedge clk);
      inc_i       = 1'b1;
      digit_sel_i = 6'b000001;
      @(negedge clk);
      check("busy_during_second_inc", 32'(busy_o), 32'h1);
      @(negedge clk);
      inc_i       = 1'b0;
      digit_sel_i = '0;
      idle(8);
      do_ref(24'h000100, 1'b0);

      // Refresh and inc in the same cycle latch the old value.
      clr_pulse();
      preload(6'b000011, 2);
      preload(6'b000010, 2);
      @(negedge clk);
      ref_i       = 1'b1;
      inc_i       = 1'b1;
      digit_sel_i = 6'b000001;
      exp_q.push_back({1'b0, 24'h000042});
      @(negedge clk);
      ref_i       = 1'b0;
      inc_i       = 1'b0;
      digit_sel_i = '0;
      idle(2);
      do_ref(24'h000043, 1'b0);

      // Async reset mid-ripple on 009999 + 1.
      clr_pulse();
      preload(6'b001111, 9);
      do_ref(24'h009999, 1'b0);
      inc_pulse(6'b000001);
      @(posedge clk);
      #2;
      check("busy_mid_ripple", 32'(busy_o), 32'h1);
      reset = 1'b1;
      #1;
      check("async_reset_count_out", 32'(count_out_o), 32'h0);
      check("async_reset_busy", 32'(busy_o), 32'h0);
      check("async_reset_overflow", 32'(overflow_o), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      idle(8);
      check("no_resume_busy", 32'(busy_o), 32'h0);
      do_ref(24'h000000, 1'b0);

      idle(4);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
